// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared appliance phase encoding and default duration widths
package wm_pkg;

    localparam int PW_DEF = 5;
    localparam int TW_DEF = 8;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_DONE  = 3'd4
    } phase_t;

endpackage

// File: rtl/wm_min_prescaler.sv
// rtl/wm_min_prescaler.sv - divides tick_en strobes down to one pulse per minute
module wm_min_prescaler
    import wm_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic en,
    input  logic clr,
    output logic minute_pulse
);

    localparam logic [7:0] LAST = 8'(TICKS_PER_MIN - 1);

    logic [7:0] cnt;

    // Pulse on the tick that completes a minute; the counter wraps on that same edge.
    assign minute_pulse = tick_en && en && (cnt == LAST);

    // Count enabled ticks; holding en low freezes the count instead of clearing it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (tick_en && en) begin
            cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wm_cycle_runner.sv
// rtl/wm_cycle_runner.sv - sequences wash, rinse and spin from latched durations
module wm_cycle_runner
    import wm_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60,
    parameter int PW            = PW_DEF,
    parameter int TW            = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_en,
    input  logic          start,
    input  logic          abort,
    input  logic          pause,
    input  logic [PW-1:0] wash_t,
    input  logic [PW-1:0] rinse_t,
    input  logic [PW-1:0] spin_t,
    output logic [2:0]    phase,
    output logic [PW-1:0] rem_phase,
    output logic [TW-1:0] rem_total,
    output logic          motor_on,
    output logic          spin_fast,
    output logic          busy,
    output logic          done
);

    localparam logic [PW-1:0] ONE_MIN = {{(PW-1){1'b0}}, 1'b1};

    phase_t        phase_q, phase_n;
    logic [PW-1:0] rem_phase_q, rem_phase_n;
    logic [TW-1:0] rem_total_q, rem_total_n;
    logic [PW-1:0] wash_q, wash_n, rinse_q, rinse_n, spin_q, spin_n;
    logic          done_q, done_n;
    logic          running, start_acc, minute_pulse;
    logic [TW-1:0] sum_in;
    phase_t        first_ph, adv_ph;

    function automatic logic [TW-1:0] widen(input logic [PW-1:0] v);
        return {{(TW-PW){1'b0}}, v};
    endfunction

    // First phase after cur (in wash, rinse, spin order) whose duration is nonzero.
    function automatic phase_t next_after(input phase_t cur, input logic [PW-1:0] w,
                                          input logic [PW-1:0] r, input logic [PW-1:0] s);
        phase_t nxt;
        nxt = PH_DONE;
        if (cur == PH_IDLE && w != '0)
            nxt = PH_WASH;
        else if ((cur == PH_IDLE || cur == PH_WASH) && r != '0)
            nxt = PH_RINSE;
        else if ((cur == PH_IDLE || cur == PH_WASH || cur == PH_RINSE) && s != '0)
            nxt = PH_SPIN;
        return nxt;
    endfunction

    function automatic logic [PW-1:0] dur_of(input phase_t ph, input logic [PW-1:0] w,
                                             input logic [PW-1:0] r, input logic [PW-1:0] s);
        logic [PW-1:0] d;
        case (ph)
            PH_WASH:  d = w;
            PH_RINSE: d = r;
            PH_SPIN:  d = s;
            default:  d = '0;
        endcase
        return d;
    endfunction

    assign running   = (phase_q == PH_WASH) || (phase_q == PH_RINSE) || (phase_q == PH_SPIN);
    assign sum_in    = widen(wash_t) + widen(rinse_t) + widen(spin_t);
    assign first_ph  = next_after(PH_IDLE, wash_t, rinse_t, spin_t);
    assign adv_ph    = next_after(phase_q, wash_q, rinse_q, spin_q);
    assign start_acc = !abort && start && (phase_q == PH_IDLE || phase_q == PH_DONE)
                       && (sum_in != '0);

    wm_min_prescaler #(
        .TICKS_PER_MIN(TICKS_PER_MIN)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .en           (running && !pause),
        .clr          (abort || start_acc),
        .minute_pulse (minute_pulse)
    );

    // Next-state: abort beats start, start beats minute timing.
    always_comb begin
        phase_n     = phase_q;
        rem_phase_n = rem_phase_q;
        rem_total_n = rem_total_q;
        wash_n      = wash_q;
        rinse_n     = rinse_q;
        spin_n      = spin_q;
        done_n      = 1'b0;
        if (abort) begin
            if (phase_q != PH_IDLE) begin
                phase_n     = PH_IDLE;
                rem_phase_n = '0;
                rem_total_n = '0;
            end
        end else if (start_acc) begin
            wash_n      = wash_t;
            rinse_n     = rinse_t;
            spin_n      = spin_t;
            phase_n     = first_ph;
            rem_phase_n = dur_of(first_ph, wash_t, rinse_t, spin_t);
            rem_total_n = sum_in;
        end else if (minute_pulse) begin
            rem_total_n = (rem_total_q != '0) ? rem_total_q - 1'b1 : '0;
            if (rem_phase_q <= ONE_MIN) begin
                if (adv_ph == PH_DONE) begin
                    phase_n     = PH_DONE;
                    rem_phase_n = '0;
                    rem_total_n = '0;
                    done_n      = 1'b1;
                end else begin
                    phase_n     = adv_ph;
                    rem_phase_n = dur_of(adv_ph, wash_q, rinse_q, spin_q);
                end
            end else begin
                rem_phase_n = rem_phase_q - 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            rem_phase_q <= '0;
            rem_total_q <= '0;
            wash_q      <= '0;
            rinse_q     <= '0;
            spin_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            phase_q     <= phase_n;
            rem_phase_q <= rem_phase_n;
            rem_total_q <= rem_total_n;
            wash_q      <= wash_n;
            rinse_q     <= rinse_n;
            spin_q      <= spin_n;
            done_q      <= done_n;
        end
    end

    assign phase     = phase_q;
    assign rem_phase = rem_phase_q;
    assign rem_total = rem_total_q;
    assign busy      = running;
    assign motor_on  = running && !pause;
    assign spin_fast = (phase_q == PH_SPIN) && !pause;
    assign done      = done_q;

endmodule

// File: tb/tb_wm_cycle_runner.sv
// tb/tb_wm_cycle_runner.sv - directed scoreboard bench for wm_cycle_runner
module tb_wm_cycle_runner;

    logic       clk = 1'b0;
    logic       rst, tick_en, start, abort, pause;
    logic [4:0] wash_t, rinse_t, spin_t;
    logic [2:0] phase;
    logic [4:0] rem_phase;
    logic [7:0] rem_total;
    logic       motor_on, spin_fast, busy, done;

    int total = 0;
    int bad   = 0;

    logic [19:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    wm_cycle_runner #(
        .TICKS_PER_MIN(2),
        .PW(5),
        .TW(8)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .abort(abort),
        .pause(pause), .wash_t(wash_t), .rinse_t(rinse_t), .spin_t(spin_t),
        .phase(phase), .rem_phase(rem_phase), .rem_total(rem_total),
        .motor_on(motor_on), .spin_fast(spin_fast), .busy(busy), .done(done)
    );

    // Packs {phase, rem_phase, rem_total, motor_on, spin_fast, busy, done}.
    function automatic logic [19:0] mk(int ph, int rp, int rt, bit m, bit sf, bit b, bit d);
        return {3'(ph), 5'(rp), 8'(rt), m, sf, b, d};
    endfunction

    // Reference: state after m whole minutes of a w/r/s programme.
    function automatic logic [19:0] model(int w, int r, int s, int m, bit p, bit d);
        int tot;
        tot = w + r + s;
        if (m >= tot) return mk(4, 0, 0, 0, 0, 0, d);
        if (m < w)     return mk(1, w - m, tot - m, !p, 0, 1, 0);
        if (m < w + r) return mk(2, w + r - m, tot - m, !p, 0, 1, 0);
        return mk(3, tot - m, tot - m, !p, !p, 1, 0);
    endfunction

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic go(input string tag, input logic [19:0] e);
        logic [19:0] got, want;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        got  = {phase, rem_phase, rem_total, motor_on, spin_fast, busy, done};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", t, got, want);
        end
    endtask

    initial begin
        rst = 1; tick_en = 0; start = 0; abort = 0; pause = 0;
        wash_t = 0; rinse_t = 0; spin_t = 0;
        go("reset", mk(0, 0, 0, 0, 0, 0, 0));
        rst = 0;
        go("idle", mk(0, 0, 0, 0, 0, 0, 0));

        // 1: nominal 2/1/3 run
        tick_en = 1; wash_t = 2; rinse_t = 1; spin_t = 3; start = 1;
        go("t1_start", model(2, 1, 3, 0, 0, 0));
        start = 0;
        for (int k = 1; k <= 12; k++) go($sformatf("t1_tick%0d", k), model(2, 1, 3, k / 2, 0, k == 12));
        go("t1_hold", mk(4, 0, 0, 0, 0, 0, 0));

        // 2: zero wash and spin are skipped
        wash_t = 0; rinse_t = 2; spin_t = 0; start = 1;
        go("t2_start", model(0, 2, 0, 0, 0, 0));
        start = 0;
        for (int k = 1; k <= 4; k++) go($sformatf("t2_tick%0d", k), model(0, 2, 0, k / 2, 0, k == 4));
        go("t2_hold", mk(4, 0, 0, 0, 0, 0, 0));

        // 3: abort from DONE, all-zero start, start while busy
        abort = 1;
        go("t3_abort_done", mk(0, 0, 0, 0, 0, 0, 0));
        abort = 0; wash_t = 0; rinse_t = 0; spin_t = 0; start = 1;
        go("t3_zero_start", mk(0, 0, 0, 0, 0, 0, 0));
        tick_en = 0; wash_t = 3; rinse_t = 0; spin_t = 1;
        go("t3_start", model(3, 0, 1, 0, 0, 0));
        tick_en = 1; wash_t = 10; rinse_t = 10; spin_t = 10;
        for (int k = 1; k <= 4; k++) go($sformatf("t3_busy_start%0d", k), model(3, 0, 1, k / 2, 0, 0));
        start = 0;

        // 4: pause with prescaler at 1
        go("t4_pre", model(3, 0, 1, 2, 0, 0));
        pause = 1;
        for (int k = 1; k <= 20; k++) go($sformatf("t4_pause%0d", k), model(3, 0, 1, 2, 1, 0));
        pause = 0;
        go("t4_release", model(3, 0, 1, 3, 0, 0));

        // 5: abort with tick at rem_phase=1 in SPIN, then abort+start in IDLE
        go("t5_pre", model(3, 0, 1, 3, 0, 0));
        abort = 1;
        go("t5_abort", mk(0, 0, 0, 0, 0, 0, 0));
        abort = 0;
        go("t5_no_done", mk(0, 0, 0, 0, 0, 0, 0));
        abort = 1; start = 1; wash_t = 4; rinse_t = 4; spin_t = 4;
        go("t5_abort_start", mk(0, 0, 0, 0, 0, 0, 0));
        abort = 0; start = 0;
        go("t5_idle", mk(0, 0, 0, 0, 0, 0, 0));

        // 6: reset during RINSE, then maximum durations
        wash_t = 3; rinse_t = 2; spin_t = 1; start = 1;
        go("t6_start", model(3, 2, 1, 0, 0, 0));
        start = 0;
        for (int k = 1; k <= 7; k++) go($sformatf("t6_tick%0d", k), model(3, 2, 1, k / 2, 0, 0));
        rst = 1;
        go("t6_reset", mk(0, 0, 0, 0, 0, 0, 0));
        rst = 0; wash_t = 31; rinse_t = 31; spin_t = 31; start = 1;
        go("t6_max_start", model(31, 31, 31, 0, 0, 0));
        start = 0;
        for (int k = 1; k <= 186; k++) go($sformatf("t6_max%0d", k), model(31, 31, 31, k / 2, 0, k == 186));
        go("t6_max_hold", mk(4, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wm_cycle_runner.md
Name: wm_cycle_runner

Overview:
Executes a washing-machine programme from the settings the control bus stores: wash, rinse and spin durations in minutes. On start it latches the three durations and sequences WASH -> RINSE -> SPIN -> DONE, counting down per-phase and total remaining time. It drives the motor and the status outputs read by the display and controller logic. One instance sits behind each washing-machine settings register.

Parameters:
TICKS_PER_MIN, 60, number of tick_en pulses per minute; range 1..255
PW, 5, width of per-phase duration in minutes
TW, 8, width of total remaining time; must be at least PW+2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_en  in  1  one-cycle timebase strobe
start  in  1  one-cycle request to begin a programme
abort  in  1  one-cycle request to cancel
pause  in  1  level; freezes timing while high
wash_t  in  PW  wash minutes
rinse_t  in  PW  rinse minutes
spin_t  in  PW  spin minutes
phase  out  3  0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE
rem_phase  out  PW  minutes left in the current phase
rem_total  out  TW  minutes left in the programme
motor_on  out  1  high in WASH/RINSE/SPIN while pause is low
spin_fast  out  1  high in SPIN while pause is low
busy  out  1  high in WASH/RINSE/SPIN
done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst sampled high at a clk edge): phase=IDLE. rem_phase, rem_total, motor_on, spin_fast, busy and done = 0. Prescaler = 0. Latched durations = 0.
- Priority each cycle: rst > abort > start > timing.
- abort in any state: next cycle IDLE with all outputs 0 and prescaler cleared. abort in IDLE has no effect.
- start is accepted only in IDLE or DONE. Accepted start with wash_t+rinse_t+spin_t = 0 is ignored and the state is unchanged.
- Accepted start:
  - Latch all three durations at that edge.
  - Next cycle: phase = first phase with a nonzero duration, in the order WASH, RINSE, SPIN.
  - Next cycle: rem_phase = that phase's duration; rem_total = the sum computed at width TW, maximum 93.
  - Next cycle: prescaler = 0.
- start while busy is ignored. Input changes while busy are ignored, because the latched values are used.
- Timing:
  - In a running phase with pause low, each tick_en increments the prescaler.
  - When a tick_en arrives with prescaler = TICKS_PER_MIN-1: prescaler -> 0, rem_phase -= 1, rem_total -= 1, all on that same edge.
  - With pause high, tick_en is ignored and the prescaler holds its value; it is not cleared.
- Phase advance happens on the same edge where rem_phase would reach 0:
  - Load the next phase in order whose latched duration is nonzero, and set rem_phase to that duration.
  - Zero-duration phases are skipped.
  - If no phase remains: phase=DONE, rem_phase=0, rem_total=0, done=1 for exactly one cycle.
- DONE holds until start or abort. motor_on and busy are 0 in DONE.
- Invariant while busy: rem_total equals rem_phase plus the latched durations of the phases not yet entered.
- No wrap-around: counters never decrement below 0.

Decomposition:
- Shared package (wm_pkg): phase encoding constants PH_IDLE..PH_DONE and default widths PW/TW. The fridge/AC blocks reuse the same package for duration widths.
- One sub-module is natural: wm_min_prescaler. It takes tick_en, an enable (running && !pause) and a clear, and outputs a one-cycle minute_pulse.

Test Plan:
1. Nominal run (TICKS_PER_MIN=2, tick_en every cycle), wash=2, rinse=1, spin=3, start -> next cycle phase=1, rem_phase=2, rem_total=6. Phase=2 after 4 ticks, phase=3 after 6, phase=4 with done pulse after 12. motor_on was high throughout the run, and spin_fast only in SPIN.
2. Skip zero phase: wash=0, rinse=2, spin=0, start -> phase=2, rem_total=2. After 4 ticks phase=4, done=1 for one cycle, rem_total=0.
3. All zero and busy-start: start with wash=rinse=spin=0 -> stays IDLE with outputs 0. Then start during WASH with new values -> ignored, rem_total keeps decrementing from the latched sum.
4. Pause mid-phase: pause high for 20 cycles in WASH with prescaler=1 -> rem_phase/rem_total frozen and motor_on=0. After release, the first tick_en decrements the counters.
5. Abort and simultaneous events: abort together with tick_en at rem_phase=1 in SPIN -> IDLE with all outputs 0 and no done pulse. abort together with start in IDLE -> stays IDLE.
6. Reset mid-operation and max values: rst during RINSE -> next cycle all outputs 0 and IDLE. Start with 31/31/31 -> rem_total=93, and it reaches 0 exactly on the done pulse.
